// File: rtl/ibus_pkg.sv
// Shared types and helpers for the simple-iBus instruction memory responder.
package ibus_pkg;

    localparam logic [2:0] IBUS_SIZE_WORD = 3'd2;

    typedef struct packed {
        logic        vld;
        logic        err;
        logic [31:0] idx;
    } ibus_pend_t;

    // The limit is computed 33 bits wide so a window ending at 4 GiB cannot wrap.
    function automatic logic ibus_addr_err(input logic [31:0] addr,
                                           input logic [2:0]  size,
                                           input logic [31:0] base,
                                           input logic [32:0] words);
        logic [32:0] lim;
        lim = {1'b0, base} + (words << 2);
        return (addr[1:0] != 2'b00) || (size != IBUS_SIZE_WORD) ||
               (addr < base) || ({1'b0, addr} >= lim);
    endfunction

endpackage

// File: rtl/ibus_delay_line.sv
// Fixed-depth shift register of pending fetches with synchronous clear.
module ibus_delay_line
    import ibus_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       clr_i,
    input  ibus_pend_t in_i,
    output ibus_pend_t pre_o,
    output logic       vld_o,
    output logic       err_o
);

    ibus_pend_t stage_q [DEPTH];
    ibus_pend_t stage_d [DEPTH];

    always_comb begin
        stage_d[0] = in_i;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    // Entry about to enter the final stage; lets the owner read memory on that edge.
    assign pre_o = stage_d[DEPTH-1];
    assign vld_o = stage_q[DEPTH-1].vld;
    assign err_o = stage_q[DEPTH-1].err;

endmodule

// File: rtl/ibus_mem_responder.sv
// VexRiscv simple-iBus slave: word memory with fixed-latency, in-order responses.
module ibus_mem_responder
    import ibus_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned LATENCY   = 2,
    localparam int unsigned AW       = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [31:0]   cmd_payload_address,
    input  logic [2:0]    cmd_payload_size,
    output logic          rsp_valid,
    output logic [31:0]   rsp_payload_data,
    output logic          rsp_payload_error,
    input  logic          stall_i,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    output logic [3:0]    outstanding
);

    logic [31:0] mem_q [MEM_WORDS];
    logic [31:0] data_q, data_d;
    logic [3:0]  out_q, out_d;
    logic        accept;
    ibus_pend_t  ent_in;
    ibus_pend_t  pre;

    assign cmd_ready = !reset && !stall_i;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        ent_in = '0;
        if (accept) begin
            ent_in.vld = 1'b1;
            ent_in.err = ibus_addr_err(cmd_payload_address, cmd_payload_size,
                                       BASE_ADDR, 33'(MEM_WORDS));
            ent_in.idx = cmd_payload_address - BASE_ADDR;
        end
    end

    ibus_delay_line #(
        .DEPTH(LATENCY)
    ) u_delay (
        .clk  (clk),
        .clr_i(reset),
        .in_i (ent_in),
        .pre_o(pre),
        .vld_o(rsp_valid),
        .err_o(rsp_payload_error)
    );

    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // Byte offset is shifted down here; upper bits must be clear before indexing.
    always_comb begin
        data_d = '0;
        if (pre.vld && !pre.err && (pre.idx[31:AW+2] == '0)) begin
            data_d = mem_q[pre.idx[AW+1:2]];
        end
    end

    always_comb begin
        out_d = out_q;
        unique case ({accept, rsp_valid})
            2'b10:   out_d = out_q + 4'd1;
            2'b01:   out_d = out_q - 4'd1;
            default: out_d = out_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            out_q  <= '0;
        end else begin
            data_q <= data_d;
            out_q  <= out_d;
        end
    end

    assign rsp_payload_data = data_q;
    assign outstanding      = out_q;

endmodule

// File: tb/tb_ibus_mem_responder.sv
// Scoreboard bench: a LATENCY=2 and a LATENCY=1 responder checked every cycle.
module tb_ibus_mem_responder;

    localparam logic [31:0] BASE = 32'h8000_0000;

    typedef struct {
        logic        err;
        logic [9:0]  idx;
        int unsigned due;
    } exp_t;

    logic        clk = 1'b0;
    logic [1:0]  reset, cmd_valid, stall, load_en;
    logic [1:0]  cmd_ready, rsp_valid, rsp_err;
    logic [31:0] addr [2];
    logic [2:0]  size [2];
    logic [9:0]  load_addr [2];
    logic [31:0] load_data [2];
    logic [31:0] rsp_data [2];
    logic [3:0]  outst [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 2 : 1;

        ibus_mem_responder #(
            .MEM_WORDS(1024),
            .BASE_ADDR(BASE),
            .LATENCY  (L)
        ) dut (
            .clk                (clk),
            .reset              (reset[g]),
            .cmd_valid          (cmd_valid[g]),
            .cmd_ready          (cmd_ready[g]),
            .cmd_payload_address(addr[g]),
            .cmd_payload_size   (size[g]),
            .rsp_valid          (rsp_valid[g]),
            .rsp_payload_data   (rsp_data[g]),
            .rsp_payload_error  (rsp_err[g]),
            .stall_i            (stall[g]),
            .load_en            (load_en[g]),
            .load_addr          (load_addr[g]),
            .load_data          (load_data[g]),
            .outstanding        (outst[g])
        );

        exp_t        sb [$];
        logic [31:0] mem_m [1024];
        int unsigned cyc = 0;
        logic        s_rst, s_acc, s_wr;
        logic [31:0] s_addr, s_wdata;
        logic [2:0]  s_size;
        logic [9:0]  s_waddr;

        initial forever begin
            @(posedge clk);
            cyc++;
            s_rst   = reset[g];
            s_acc   = cmd_valid[g] && !reset[g] && !stall[g];
            s_addr  = addr[g];
            s_size  = size[g];
            s_wr    = load_en[g];
            s_waddr = load_addr[g];
            s_wdata = load_data[g];
        end

        initial forever begin
            exp_t        e;
            logic [31:0] off;
            logic        exp_v;
            @(negedge clk);
            if (s_rst) sb.delete();
            if (s_acc) begin
                off   = s_addr - BASE;
                e.err = (s_addr[1:0] != 2'b00) || (s_size != 3'd2) ||
                        (s_addr < BASE) || (s_addr >= BASE + 32'h0000_1000);
                e.idx = off[11:2];
                e.due = cyc + L - 1;
                sb.push_back(e);
            end
            exp_v = (sb.size() != 0) && (sb[0].due == cyc);
            check($sformatf("u%0d.ready@%0d", g, cyc), {31'd0, cmd_ready[g]},
                  {31'd0, !reset[g] && !stall[g]});
            check($sformatf("u%0d.outstanding@%0d", g, cyc), {28'd0, outst[g]}, sb.size());
            check($sformatf("u%0d.valid@%0d", g, cyc), {31'd0, rsp_valid[g]}, {31'd0, exp_v});
            if (exp_v) begin
                e = sb.pop_front();
                check($sformatf("u%0d.data@%0d", g, cyc), rsp_data[g], e.err ? 32'd0 : mem_m[e.idx]);
                check($sformatf("u%0d.error@%0d", g, cyc), {31'd0, rsp_err[g]}, {31'd0, e.err});
            end else begin
                check($sformatf("u%0d.idle_data@%0d", g, cyc), rsp_data[g], 32'd0);
                check($sformatf("u%0d.idle_error@%0d", g, cyc), {31'd0, rsp_err[g]}, 32'd0);
            end
            if (s_wr) mem_m[s_waddr] = s_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic fetch(input int g, input logic [31:0] a, input logic [2:0] sz);
        cmd_valid[g] = 1'b1;
        addr[g]      = a;
        size[g]      = sz;
        tick();
        cmd_valid[g] = 1'b0;
    endtask

    task automatic load(input int g, input logic [9:0] wa, input logic [31:0] d);
        load_en[g]   = 1'b1;
        load_addr[g] = wa;
        load_data[g] = d;
        tick();
        load_en[g]   = 1'b0;
    endtask

    initial begin
        reset     = 2'b11;
        cmd_valid = '0;
        stall     = '0;
        load_en   = '0;
        for (int i = 0; i < 2; i++) begin
            addr[i]      = '0;
            size[i]      = 3'd2;
            load_addr[i] = '0;
            load_data[i] = '0;
        end
        idle(3);
        reset = '0;

        for (int g = 0; g < 2; g++) begin
            load(g, 10'd0, 32'h0000_0013);
            load(g, 10'd1, 32'h0010_0093);
            for (int i = 2; i < 32; i++) load(g, 10'(i), $urandom);
            load(g, 10'd1023, 32'hCAFE_F00D);
        end

        // Back-to-back valid fetches.
        fetch(0, 32'h8000_0000, 3'd2);
        fetch(0, 32'h8000_0004, 3'd2);
        idle(4);

        // Error cases and the last legal word.
        fetch(0, 32'h8000_0002, 3'd2);
        fetch(0, 32'h7FFF_FFFC, 3'd2);
        fetch(0, 32'h8000_1000, 3'd2);
        fetch(0, 32'h8000_0008, 3'd1);
        fetch(0, 32'h8000_0FFC, 3'd2);
        fetch(0, 32'hFFFF_FFFC, 3'd2);
        idle(4);

        // Stall with a response still in flight.
        fetch(0, 32'h8000_0008, 3'd2);
        stall[0]     = 1'b1;
        cmd_valid[0] = 1'b1;
        addr[0]      = 32'h8000_000C;
        size[0]      = 3'd2;
        idle(3);
        stall[0] = 1'b0;
        tick();
        cmd_valid[0] = 1'b0;
        idle(4);

        // Write to word 5 on the same edge its read happens.
        fetch(0, 32'h8000_0014, 3'd2);
        load(0, 10'd5, 32'hDEAD_BEEF);
        fetch(0, 32'h8000_0014, 3'd2);
        idle(4);

        // Reset with two requests accepted.
        fetch(0, 32'h8000_0000, 3'd2);
        cmd_valid[0] = 1'b1;
        addr[0]      = 32'h8000_0004;
        tick();
        cmd_valid[0] = 1'b0;
        reset[0]     = 1'b1;
        idle(2);
        reset[0] = 1'b0;
        fetch(0, 32'h8000_0000, 3'd2);
        fetch(0, 32'h8000_0004, 3'd2);
        fetch(0, 32'h8000_0014, 3'd2);
        fetch(0, 32'h8000_0FFC, 3'd2);
        idle(4);

        // LATENCY=1 unit: 16 back-to-back random in-range fetches.
        for (int i = 0; i < 16; i++) begin
            fetch(1, BASE + ($urandom_range(31, 0) << 2), 3'd2);
        end
        idle(6);

        check("u0.drain", g_dut[0].sb.size(), 0);
        check("u1.drain", g_dut[1].sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
